// File: rtl/vdp_scandbl_ctrl.sv
// vdp_scandbl_ctrl: scan-doubler controller for the VDP VGA path.
// Writes one source line into bank EVENODD of a double-buffered line memory while the
// other bank is read out twice at the VGA line rate. Read data is registered into
// blanked VGA RGB with HSYNC and DE, all with a 2-clock delay from the read counter.
// Optional build macro: VDP_SCANDBL_SCANLINE_EN halves the colour of the second repeat.
module vdp_scandbl_ctrl #(
  parameter int unsigned H_TOTAL  = 684,
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 80
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SRC_LINE_START,
  input  logic       SRC_PIX_EN,
  input  logic [5:0] SRC_R,
  input  logic [5:0] SRC_G,
  input  logic [5:0] SRC_B,
  output logic [9:0] XPOSITIONW,
  output logic [9:0] XPOSITIONR,
  output logic       EVENODD,
  output logic       WE,
  output logic [5:0] DATARIN,
  output logic [5:0] DATAGIN,
  output logic [5:0] DATABIN,
  input  logic [5:0] DATAROUT,
  input  logic [5:0] DATAGOUT,
  input  logic [5:0] DATABOUT,
  output logic [5:0] VGA_R,
  output logic [5:0] VGA_G,
  output logic [5:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_DE
);

  localparam int unsigned RCNT_W   = $clog2(H_TOTAL);
  localparam int unsigned WCNT_W   = 11;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;

`ifdef VDP_SCANDBL_SCANLINE_EN
  localparam bit SCANLINE = 1'b1;
`else
  localparam bit SCANLINE = 1'b0;
`endif

  // Reject timing sets that do not fit a line or exceed the 10-bit buffer address.
  if ((H_ACTIVE + H_FP + H_SYNC > H_TOTAL) || (H_ACTIVE > 1024)) begin : g_cfg_check
    $error("vdp_scandbl_ctrl: invalid horizontal timing parameters");
  end

  // Write side state
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic              eo_q, eo_d;
  logic [9:0]        xw_q, xw_d;
  logic [5:0]        dr_q, dr_d, dg_q, dg_d, db_q, db_d;

  // Read side and output pipeline state
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              half_q, half_d;
  logic [9:0]        xr_q, xr_d;
  logic              act1_q, act1_d;
  logic              half1_q, half1_d;
  logic              hs1_q, hs1_d;
  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic [5:0]        vr_q, vr_d, vg_q, vg_d, vb_q, vb_d;

  // Write address/data generation and bank swap on each source line start.
  always_comb begin
    wcnt_d = wcnt_q;
    we_d   = 1'b0;
    eo_d   = eo_q;
    xw_d   = xw_q;
    dr_d   = dr_q;
    dg_d   = dg_q;
    db_d   = db_q;
    if (SRC_LINE_START) begin
      wcnt_d = '0;
      eo_d   = ~eo_q;
    end else if (SRC_PIX_EN && (32'(wcnt_q) < H_ACTIVE)) begin
      we_d   = 1'b1;
      xw_d   = wcnt_q[9:0];
      dr_d   = SRC_R;
      dg_d   = SRC_G;
      db_d   = SRC_B;
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  // Free-running read counter with resync on source line start; 2-stage output pipeline.
  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    half_d = half_q;
    if (SRC_LINE_START) begin
      rcnt_d = '0;
      half_d = 1'b0;
    end else if (32'(rcnt_q) == H_TOTAL - 1) begin
      rcnt_d = '0;
      half_d = ~half_q;
    end
    xr_d    = (32'(rcnt_d) < H_ACTIVE) ? 10'(rcnt_d) : 10'd0;
    act1_d  = (32'(rcnt_q) < H_ACTIVE);
    half1_d = half_q;
    hs1_d   = !((32'(rcnt_q) >= HS_START) && (32'(rcnt_q) < HS_END));
    de_d    = act1_q;
    hs_d    = hs1_q;
    vr_d    = '0;
    vg_d    = '0;
    vb_d    = '0;
    if (act1_q) begin
      if (SCANLINE && half1_q) begin
        vr_d = {1'b0, DATAROUT[5:1]};
        vg_d = {1'b0, DATAGOUT[5:1]};
        vb_d = {1'b0, DATABOUT[5:1]};
      end else begin
        vr_d = DATAROUT;
        vg_d = DATAGOUT;
        vb_d = DATABOUT;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      eo_q    <= 1'b0;
      xw_q    <= '0;
      dr_q    <= '0;
      dg_q    <= '0;
      db_q    <= '0;
      rcnt_q  <= '0;
      half_q  <= 1'b0;
      xr_q    <= '0;
      act1_q  <= 1'b0;
      half1_q <= 1'b0;
      hs1_q   <= 1'b1;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vr_q    <= '0;
      vg_q    <= '0;
      vb_q    <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      eo_q    <= eo_d;
      xw_q    <= xw_d;
      dr_q    <= dr_d;
      dg_q    <= dg_d;
      db_q    <= db_d;
      rcnt_q  <= rcnt_d;
      half_q  <= half_d;
      xr_q    <= xr_d;
      act1_q  <= act1_d;
      half1_q <= half1_d;
      hs1_q   <= hs1_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vr_q    <= vr_d;
      vg_q    <= vg_d;
      vb_q    <= vb_d;
    end
  end

  assign XPOSITIONW = xw_q;
  assign XPOSITIONR = xr_q;
  assign EVENODD    = eo_q;
  assign WE         = we_q;
  assign DATARIN    = dr_q;
  assign DATAGIN    = dg_q;
  assign DATABIN    = db_q;
  assign VGA_R      = vr_q;
  assign VGA_G      = vg_q;
  assign VGA_B      = vb_q;
  assign VGA_HS     = hs_q;
  assign VGA_DE     = de_q;

endmodule

// File: tb/tb_vdp_scandbl_ctrl.sv
// Testbench for vdp_scandbl_ctrl: random source lines, an emulated line memory, and
// scoreboards for the write port and the VGA output stream.
module tb_vdp_scandbl_ctrl;

  localparam int HT  = 684;
  localparam int HA  = 512;
  localparam int HFP = 16;
  localparam int HSY = 80;

  typedef struct packed {
    logic [9:0]  a;
    logic [17:0] d;
    logic        eo;
  } wexp_t;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic [17:0] rgb;
  } vexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET, SRC_LINE_START, SRC_PIX_EN;
  logic [5:0] SRC_R, SRC_G, SRC_B;
  logic [9:0] XPOSITIONW, XPOSITIONR;
  logic       EVENODD, WE;
  logic [5:0] DATARIN, DATAGIN, DATABIN;
  logic [5:0] DATAROUT, DATAGOUT, DATABOUT;
  logic [5:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_DE;

  vdp_scandbl_ctrl dut (
    .CLK(clk), .RESET(RESET), .SRC_LINE_START(SRC_LINE_START), .SRC_PIX_EN(SRC_PIX_EN),
    .SRC_R(SRC_R), .SRC_G(SRC_G), .SRC_B(SRC_B),
    .XPOSITIONW(XPOSITIONW), .XPOSITIONR(XPOSITIONR), .EVENODD(EVENODD), .WE(WE),
    .DATARIN(DATARIN), .DATAGIN(DATAGIN), .DATABIN(DATABIN),
    .DATAROUT(DATAROUT), .DATAGOUT(DATAGOUT), .DATABOUT(DATABOUT),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_DE(VGA_DE)
  );

  // Line memory emulation: two banks, synchronous read with 1-clock latency.
  logic [17:0] mem [0:1][0:1023];
  always @(posedge clk) begin
    if (WE) mem[EVENODD][XPOSITIONW] <= {DATARIN, DATAGIN, DATABIN};
    {DATAROUT, DATAGOUT, DATABOUT} <= mem[EVENODD ^ 1'b1][XPOSITIONR];
  end

  // Reference model state: pixels written per bank, time since last line start.
  logic [17:0] mdl_bank [0:1][0:1023];
  int          t;
  logic        m_eo;
  int          wc;
  logic        started = 1'b0;
  wexp_t       wq[$];
  vexp_t       vq[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, want);
  endtask

  // Expected VGA output two clocks after the current model time.
  function automatic vexp_t exp_out();
    vexp_t v;
    int pos, half;
    logic [17:0] px;
    pos   = t % HT;
    half  = (t / HT) % 2;
    v.de  = (pos < HA);
    v.hs  = !((pos >= HA + HFP) && (pos < HA + HFP + HSY));
    v.rgb = '0;
    if (v.de) begin
      px = mdl_bank[m_eo ^ 1'b1][pos];
`ifdef VDP_SCANDBL_SCANLINE_EN
      if (half == 1) px = {1'b0, px[17:13], 1'b0, px[11:7], 1'b0, px[5:1]};
`else
      if (half > 1) px = '0;
`endif
      v.rgb = px;
    end
    return v;
  endfunction

  // Drive one clock of stimulus, then advance the reference model.
  task automatic cycle(input logic rst, input logic ls, input logic pe, input logic [17:0] d);
    vexp_t rv;
    RESET = rst;
    SRC_LINE_START = ls;
    SRC_PIX_EN = pe;
    {SRC_R, SRC_G, SRC_B} = d;
    @(posedge clk);
    #1;
    if (rst) begin
      t = 0;
      m_eo = 1'b0;
      wc = 0;
      wq.delete();
      vq.delete();
      rv = '{de: 1'b0, hs: 1'b1, rgb: 18'd0};
      vq.push_back(rv);
      vq.push_back(rv);
      started = 1'b1;
    end else if (ls) begin
      t = 0;
      m_eo = ~m_eo;
      wc = 0;
    end else begin
      t++;
      if (pe && wc < HA) begin
        mdl_bank[m_eo][wc] = d;
        wq.push_back('{a: 10'(wc), d: d, eo: m_eo});
        wc++;
      end
    end
    vq.push_back(exp_out());
  endtask

  // One source line: line-start clock followed by len clocks of pixels.
  // mode 0: every 2nd clock, R = pixel index; 1: random; 2: all 63 every clock.
  task automatic run_line(input int len, input int mode);
    int n;
    logic pe;
    logic [17:0] d;
    n = 0;
    cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 18'($urandom));
    for (int c = 0; c < len; c++) begin
      case (mode)
        0: begin pe = ((c % 2) == 1) && (c < 1040); d = {6'(n), 12'($urandom)}; end
        1: begin pe = 1'($urandom_range(0, 1)); d = 18'($urandom); end
        default: begin pe = (c < 600); d = '1; end
      endcase
      cycle(1'b0, 1'b0, pe, d);
      if (pe) n++;
    end
  endtask

  // Monitor: write-port scoreboard, bank select, and VGA output stream.
  always @(negedge clk) begin
    wexp_t we_e;
    vexp_t ve;
    if (started) begin
      chk("evenodd", 32'(EVENODD), 32'(m_eo));
      if (WE) begin
        if (wq.size() == 0) chk("we_unexpected", 32'(WE), 32'd0);
        else begin
          we_e = wq.pop_front();
          chk("wr_addr", 32'(XPOSITIONW), 32'(we_e.a));
          chk("wr_data", 32'({DATARIN, DATAGIN, DATABIN}), 32'(we_e.d));
          chk("wr_bank", 32'(EVENODD), 32'(we_e.eo));
        end
      end else if (wq.size() != 0) begin
        chk("we_missing", 32'(WE), 32'd1);
        void'(wq.pop_front());
      end
      if (vq.size() >= 3) begin
        ve = vq.pop_front();
        chk("vga", 32'({VGA_DE, VGA_HS, VGA_R, VGA_G, VGA_B}), 32'(ve));
      end
    end
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 1024; i++) begin
        mem[b][i] = '0;
        mdl_bank[b][i] = '0;
      end
    RESET = 1'b1;
    SRC_LINE_START = 1'b0;
    SRC_PIX_EN = 1'b0;
    {SRC_R, SRC_G, SRC_B} = '0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("rst_hs", 32'(VGA_HS), 32'd1);
    chk("rst_de", 32'(VGA_DE), 32'd0);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_eo", 32'(EVENODD), 32'd0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);

    run_line(2 * HT, 0);
    run_line(2 * HT, 2);
    run_line(2 * HT, 1);
    run_line(300, 1);
    run_line(3 * HT + 100, 1);
    run_line(700, 1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b1, 18'($urandom));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    run_line(2 * HT, 0);
    run_line(2 * HT, 1);
    run_line(2 * HT, 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
